polyline_seq: RTL and testbench

- Upstream command stage for the line drawer.
- Accepts a stream of 8-bit vertices over a valid/ready handshake and buffers them in a small FIFO.
- Issues one line-draw command per consecutive vertex pair: start pulse plus endpoints. Waits for the drawer's done pulse before issuing the next pair.
- Optionally closes the polygon with a final last-to-first segment.

---
 rtl/polyline_seq.sv | 219 +++++++++++++++++++++
 tb/tb_polyline_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyline_seq.sv
// Polyline command sequencer: buffers vertices in a small FIFO and issues one
// line-draw command per consecutive vertex pair, with an optional closing segment.
module polyline_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vtx_valid_i,
  output logic       vtx_ready_o,
  input  logic [7:0] vtx_x_i,
  input  logic [7:0] vtx_y_i,
  input  logic       vtx_last_i,
  input  logic       close_en_i,
  output logic       line_start_o,
  output logic [7:0] x0_o,
  output logic [7:0] y0_o,
  output logic [7:0] x1_o,
  output logic [7:0] y1_o,
  input  logic       line_done_i,
  output logic       busy_o,
  output logic       poly_done_o,
  output logic [7:0] seg_count_o
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StNext,
    StIssue,
    StWait,
    StClose,
    StDone
  } state_e;

  state_e state_q;

  // Vertex FIFO storage: {last, x, y}
  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;
  logic          empty;
  logic [16:0]   rd_data;
  logic          pop_last;
  logic [7:0]    pop_x;
  logic [7:0]    pop_y;

  // Sequencer registers
  logic [7:0] prev_x_q, prev_y_q;
  logic [7:0] cur_x_q, cur_y_q;
  logic [7:0] origin_x_q, origin_y_q;
  logic       cur_last_q;
  logic       close_req_q;
  logic       closing_q;
  logic       multi_q;
  logic       line_start_q;
  logic       poly_done_q;
  logic       busy_q;
  logic [7:0] x0_q, y0_q, x1_q, y1_q;
  logic [7:0] seg_count_q;

  assign empty       = (count_q == '0);
  assign vtx_ready_o = (count_q != FullCount);
  assign push        = vtx_valid_i && vtx_ready_o;
  assign rd_data     = mem_q[rd_ptr_q];
  assign pop_last    = rd_data[16];
  assign pop_x       = rd_data[15:8];
  assign pop_y       = rd_data[7:0];

  always_comb begin
    pop = 1'b0;
    if (!empty && (state_q == StIdle || state_q == StNext)) begin
      pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {vtx_last_i, vtx_x_i, vtx_y_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      origin_x_q   <= '0;
      origin_y_q   <= '0;
      cur_last_q   <= 1'b0;
      close_req_q  <= 1'b0;
      closing_q    <= 1'b0;
      multi_q      <= 1'b0;
      line_start_q <= 1'b0;
      poly_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      seg_count_q  <= '0;
    end else begin
      line_start_q <= 1'b0;
      poly_done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            origin_x_q  <= pop_x;
            origin_y_q  <= pop_y;
            prev_x_q    <= pop_x;
            prev_y_q    <= pop_y;
            close_req_q <= close_en_i;
            seg_count_q <= '0;
            multi_q     <= 1'b0;
            busy_q      <= 1'b1;
            if (pop_last) begin
              // Single-point polyline: degenerate segment, never closed
              cur_x_q    <= pop_x;
              cur_y_q    <= pop_y;
              cur_last_q <= 1'b1;
              state_q    <= StIssue;
            end else begin
              state_q <= StNext;
            end
          end
        end
        StNext: begin
          if (!empty) begin
            cur_x_q    <= pop_x;
            cur_y_q    <= pop_y;
            cur_last_q <= pop_last;
            multi_q    <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          x0_q         <= prev_x_q;
          y0_q         <= prev_y_q;
          x1_q         <= cur_x_q;
          y1_q         <= cur_y_q;
          line_start_q <= 1'b1;
          if (seg_count_q != 8'hFF) begin
            seg_count_q <= seg_count_q + 8'd1;
          end
          state_q <= StWait;
        end
        StWait: begin
          // A done coincident with our own start pulse cannot belong to this segment
          if (line_done_i && !line_start_q) begin
            if (closing_q) begin
              state_q <= StDone;
            end else if (!cur_last_q) begin
              prev_x_q <= cur_x_q;
              prev_y_q <= cur_y_q;
              state_q  <= StNext;
            end else if (close_req_q && multi_q) begin
              state_q <= StClose;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StClose: begin
          prev_x_q  <= cur_x_q;
          prev_y_q  <= cur_y_q;
          cur_x_q   <= origin_x_q;
          cur_y_q   <= origin_y_q;
          closing_q <= 1'b1;
          state_q   <= StIssue;
        end
        StDone: begin
          poly_done_q <= 1'b1;
          closing_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign line_start_o = line_start_q;
  assign poly_done_o  = poly_done_q;
  assign busy_o       = busy_q;
  assign x0_o         = x0_q;
  assign y0_o         = y0_q;
  assign x1_o         = x1_q;
  assign y1_o         = y1_q;
  assign seg_count_o  = seg_count_q;

endmodule

// File: tb/tb_polyline_seq.sv
// Scoreboard bench for polyline_seq: a polyline-level model predicts the segment
// list, a monitor compares every line_start/poly_done against it.
module tb_polyline_seq;

  typedef struct {
    int x;
    int y;
  } vtx_t;

  typedef struct {
    int x0;
    int y0;
    int x1;
    int y1;
    int cnt;
  } seg_t;

  logic       clk;
  logic       rst_n;
  logic       vtx_valid;
  logic       vtx_ready;
  logic [7:0] vtx_x;
  logic [7:0] vtx_y;
  logic       vtx_last;
  logic       close_en;
  logic       line_start;
  logic [7:0] x0, y0, x1, y1;
  logic       line_done;
  logic       busy;
  logic       poly_done;
  logic [7:0] seg_count;

  logic dr_done;
  logic spur_done;
  logic hold_done;

  int checks = 0;
  int failures = 0;
  int n_starts = 0;
  int n_polys = 0;
  int polys_expected = 0;

  vtx_t pl[$];
  seg_t exp_seg[$];
  int   exp_poly[$];
  seg_t mon_s;
  int   mon_p;

  assign line_done = dr_done | spur_done;

  polyline_seq #(
    .DEPTH(4),
    .AW   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vtx_valid_i (vtx_valid),
    .vtx_ready_o (vtx_ready),
    .vtx_x_i     (vtx_x),
    .vtx_y_i     (vtx_y),
    .vtx_last_i  (vtx_last),
    .close_en_i  (close_en),
    .line_start_o(line_start),
    .x0_o        (x0),
    .y0_o        (y0),
    .x1_o        (x1),
    .y1_o        (y1),
    .line_done_i (line_done),
    .busy_o      (busy),
    .poly_done_o (poly_done),
    .seg_count_o (seg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: segment list of a whole polyline from its vertex list
  task automatic expect_poly(input bit close);
    int n;
    seg_t s;
    n = pl.size();
    if (n == 1) begin
      s = '{pl[0].x, pl[0].y, pl[0].x, pl[0].y, 1};
      exp_seg.push_back(s);
      exp_poly.push_back(1);
    end else begin
      for (int i = 0; i < n - 1; i++) begin
        s = '{pl[i].x, pl[i].y, pl[i+1].x, pl[i+1].y, i + 1};
        exp_seg.push_back(s);
      end
      if (close) begin
        s = '{pl[n-1].x, pl[n-1].y, pl[0].x, pl[0].y, n};
        exp_seg.push_back(s);
        exp_poly.push_back(n);
      end else begin
        exp_poly.push_back(n - 1);
      end
    end
    polys_expected++;
  endtask

  task automatic add_v(input int x, input int y);
    vtx_t v;
    v = '{x, y};
    pl.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic push_vtx(input int x, input int y, input bit last);
    int t;
    vtx_x = 8'(x);
    vtx_y = 8'(y);
    vtx_last = last;
    vtx_valid = 1'b1;
    t = 0;
    while (!vtx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("push_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic drive_poly(input int gapmax);
    int g;
    for (int i = 0; i < pl.size(); i++) begin
      push_vtx(pl[i].x, pl[i].y, i == pl.size() - 1);
      g = (gapmax > 0) ? int'($urandom_range(gapmax)) : 0;
      if (g > 0) begin
        vtx_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    vtx_valid = 1'b0;
  endtask

  task automatic wait_polys();
    int t;
    t = 0;
    while (n_polys < polys_expected && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("poly_done_timeout", n_polys, polys_expected);
  endtask

  task automatic pulse_spur();
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a command or completion
  always @(negedge clk) begin
    if (rst_n) begin
      if (line_start) begin
        n_starts++;
        chk("busy_at_start", int'(busy), 1);
        if (exp_seg.size() == 0) begin
          chk("unexpected_line_start", 1, 0);
        end else begin
          mon_s = exp_seg.pop_front();
          chk("x0", int'(x0), mon_s.x0);
          chk("y0", int'(y0), mon_s.y0);
          chk("x1", int'(x1), mon_s.x1);
          chk("y1", int'(y1), mon_s.y1);
          chk("seg_count_at_start", int'(seg_count), mon_s.cnt);
        end
      end
      if (poly_done) begin
        n_polys++;
        if (exp_poly.size() == 0) begin
          chk("unexpected_poly_done", 1, 0);
        end else begin
          mon_p = exp_poly.pop_front();
          chk("seg_count_at_poly_done", int'(seg_count), mon_p);
        end
      end
    end
  end

  // Drawer model: answers each start after a few cycles, checking endpoint stability
  always begin
    @(negedge clk);
    if (rst_n && line_start) begin
      logic [31:0] snap;
      int d;
      int ok;
      int ab;
      int t;
      snap = {x0, y0, x1, y1};
      d = int'($urandom_range(3, 8));
      ok = 1;
      ab = 0;
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        if (!rst_n) begin
          ab = 1;
          break;
        end
        if ({x0, y0, x1, y1} != snap) ok = 0;
      end
      t = 0;
      while (ab == 0 && hold_done && t < 3000) begin
        @(negedge clk);
        t++;
        if (!rst_n) ab = 1;
        else if ({x0, y0, x1, y1} != snap) ok = 0;
      end
      if (ab == 0) begin
        chk("endpoints_stable", ok, 1);
        dr_done = 1'b1;
        @(negedge clk);
        dr_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    int n;
    bit cl;
    rst_n = 1'b0;
    vtx_valid = 1'b0;
    vtx_x = '0;
    vtx_y = '0;
    vtx_last = 1'b0;
    close_en = 1'b0;
    dr_done = 1'b0;
    spur_done = 1'b0;
    hold_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", int'(vtx_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_line_start", int'(line_start), 0);
    chk("reset_seg_count", int'(seg_count), 0);
    chk("reset_endpoints", int'({x0, y0, x1, y1}), 0);

    // Simple open segment
    close_en = 1'b0;
    pl.delete(); add_v(10, 10); add_v(20, 15);
    expect_poly(1'b0);
    drive_poly(0);
    wait_polys();
    chk("busy_after_done", int'(busy), 0);

    // Spurious done while idle
    base = n_starts;
    pulse_spur();
    chk("idle_spur_busy", int'(busy), 0);
    chk("idle_spur_starts", n_starts, base);

    // Spurious done while waiting for the second vertex
    pl.delete(); add_v(30, 40); add_v(50, 60);
    expect_poly(1'b0);
    push_vtx(30, 40, 1'b0);
    vtx_valid = 1'b0;
    repeat (4) @(negedge clk);
    pulse_spur();
    chk("next_spur_busy", int'(busy), 1);
    chk("next_spur_starts", n_starts, base);
    push_vtx(50, 60, 1'b1);
    vtx_valid = 1'b0;
    wait_polys();

    // Closed triangle
    close_en = 1'b1;
    pl.delete(); add_v(0, 0); add_v(8, 0); add_v(8, 8);
    expect_poly(1'b1);
    drive_poly(0);
    wait_polys();

    // Single vertex with close requested
    pl.delete(); add_v(5, 7);
    expect_poly(1'b1);
    drive_poly(0);
    wait_polys();

    // Six vertices back-to-back with the drawer stalled: FIFO fills and wraps
    pl.delete();
    for (int i = 0; i < 6; i++) add_v(int'($urandom_range(255)), int'($urandom_range(255)));
    expect_poly(1'b1);
    hold_done = 1'b1;
    drive_poly(0);
    @(negedge clk);
    chk("ready_low_when_full", int'(vtx_ready), 0);
    chk("busy_while_stalled", int'(busy), 1);
    hold_done = 1'b0;
    wait_polys();

    // Random polylines, two per group pushed back to back
    for (int g = 0; g < 12; g++) begin
      cl = 1'($urandom_range(1));
      close_en = cl;
      for (int p = 0; p < 2; p++) begin
        pl.delete();
        n = int'($urandom_range(1, 5));
        for (int i = 0; i < n; i++) add_v(int'($urandom_range(255)), int'($urandom_range(255)));
        expect_poly(cl);
        drive_poly(2);
      end
      wait_polys();
    end

    // Reset during the second segment's wait
    close_en = 1'b0;
    pl.delete(); add_v(1, 2); add_v(3, 4); add_v(5, 6);
    expect_poly(1'b0);
    base = n_starts;
    drive_poly(0);
    t = 0;
    while (n_starts < base + 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("second_start_seen", int'(n_starts >= base + 2), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_line_start", int'(line_start), 0);
    chk("rst_poly_done", int'(poly_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_endpoints", int'({x0, y0, x1, y1}), 0);
    chk("rst_seg_count", int'(seg_count), 0);
    exp_seg.delete();
    exp_poly.delete();
    polys_expected = n_polys;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", int'(vtx_ready), 1);
    pl.delete(); add_v(100, 200); add_v(150, 50);
    expect_poly(1'b0);
    drive_poly(0);
    wait_polys();
    repeat (5) @(negedge clk);

    chk("leftover_segments", exp_seg.size(), 0);
    chk("leftover_polys", exp_poly.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
